// File: rtl/simd_router_pkg.sv
// Shared types and mode constants for the SIMD mode router and its bench.
// MAC_BW is the lane width of the MAC datapath unless the build provides it.
`ifndef MAC_BW
`define MAC_BW 16
`endif

package simd_router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } router_state_e;

    localparam int MODE_MAC = 0;
    localparam int MODE_DIV = 1;
    localparam int MODE_EXP = 2;
    localparam int MODE_LOG = 3;

endpackage

// File: rtl/inflight_counter.sv
// Saturating up/down count of vectors issued to a unit group but not yet completed.
// A decrement at zero is dropped and flagged instead of wrapping.
module inflight_counter #(
    parameter int MAX_COUNT = 15,
    parameter int CNT_W     = $clog2(MAX_COUNT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             underflow
);

    logic [CNT_W-1:0] r_count;
    logic             w_do_inc;
    logic             w_do_dec;

    assign full      = (r_count == CNT_W'(MAX_COUNT));
    assign empty     = (r_count == {CNT_W{1'b0}});
    assign underflow = dec & empty;
    assign count     = r_count;

    // Qualify the requests so the count never leaves [0, MAX_COUNT].
    always_comb begin
        w_do_inc = inc & (~full | dec);
        w_do_dec = dec & ~empty;
    end

    // Count register; a simultaneous increment and decrement cancel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= {CNT_W{1'b0}};
        end else if (w_do_inc & ~w_do_dec) begin
            r_count <= r_count + CNT_W'(1);
        end else if (w_do_dec & ~w_do_inc) begin
            r_count <= r_count - CNT_W'(1);
        end else begin
            r_count <= r_count;
        end
    end

endmodule

// File: rtl/simd_mode_router.sv
// Registered router steering one operand-vector pair per handshake to one of
// NUM_MODES unit groups, draining the old group before a mode change.
module simd_mode_router
    import simd_router_pkg::*;
#(
    parameter int NUM_LANES    = 64,
    parameter int DATA_W       = `MAC_BW,
    parameter int NUM_MODES    = 4,
    parameter int MAX_INFLIGHT = 15,
    localparam int MODE_W      = $clog2(NUM_MODES),
    localparam int CNT_W       = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [MODE_W-1:0]                            in_mode,
    input  logic [NUM_LANES-1:0][DATA_W-1:0]             iA,
    input  logic [NUM_LANES-1:0][DATA_W-1:0]             iB,
    output logic [NUM_MODES-1:0]                         out_valid,
    input  logic [NUM_MODES-1:0]                         out_ready,
    output logic [NUM_MODES-1:0][NUM_LANES-1:0][DATA_W-1:0] oA,
    output logic [NUM_MODES-1:0][NUM_LANES-1:0][DATA_W-1:0] oB,
    input  logic [NUM_MODES-1:0]                         unit_done,
    output logic [MODE_W-1:0]                            cur_mode,
    output logic [CNT_W-1:0]                             inflight,
    output logic                                         err_done
);

    router_state_e                    r_state;
    router_state_e                    w_next_state;
    logic [MODE_W-1:0]                r_cur_mode;
    logic [NUM_MODES-1:0]             r_out_valid;
    logic [NUM_LANES-1:0][DATA_W-1:0] r_data_a;
    logic [NUM_LANES-1:0][DATA_W-1:0] r_data_b;
    logic                             r_err_done;

    logic [NUM_MODES-1:0] w_in_onehot;
    logic [NUM_MODES-1:0] w_cur_onehot;
    logic                 w_held;
    logic                 w_issue;
    logic                 w_load;
    logic                 w_in_ready;
    logic                 w_room;
    logic                 w_dec;
    logic                 w_foreign_done;
    logic                 w_underflow;
    logic                 w_cnt_full;
    logic                 w_cnt_empty;
    logic [CNT_W-1:0]     w_inflight;
    logic [CNT_W:0]       w_occupancy;

    // One-hot views of the requested mode and the owning mode.
    always_comb begin
        w_in_onehot  = {NUM_MODES{1'b0}};
        w_cur_onehot = {NUM_MODES{1'b0}};
        for (int m = 0; m < NUM_MODES; m++) begin
            w_in_onehot[m]  = (in_mode == MODE_W'(m));
            w_cur_onehot[m] = (r_cur_mode == MODE_W'(m));
        end
    end

    assign w_held         = |r_out_valid;
    assign w_issue        = |(r_out_valid & out_ready);
    assign w_dec          = |(unit_done & w_cur_onehot);
    assign w_foreign_done = |(unit_done & ~w_cur_onehot);
    // The held vector counts against the budget so a full register never overcommits.
    assign w_occupancy    = {1'b0, w_inflight} + {{CNT_W{1'b0}}, w_held};
    assign w_room         = ~w_cnt_full & (w_occupancy < (CNT_W + 1)'(MAX_INFLIGHT));

    inflight_counter #(
        .MAX_COUNT (MAX_INFLIGHT),
        .CNT_W     (CNT_W)
    ) u_inflight_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (w_issue),
        .dec       (w_dec),
        .count     (w_inflight),
        .full      (w_cnt_full),
        .empty     (w_cnt_empty),
        .underflow (w_underflow)
    );

    // Next-state and accept decision; in_valid only steers transitions, never in_ready.
    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_load       = 1'b1;
                    w_next_state = ST_RUN;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RUN: begin
                w_in_ready = (in_mode == r_cur_mode) & (~w_held | w_issue) & w_room;
                if (in_valid & w_in_ready) begin
                    w_load       = 1'b1;
                    w_next_state = ST_RUN;
                end else if (in_valid & (in_mode != r_cur_mode)) begin
                    w_next_state = ST_DRAIN;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (~w_held & w_cnt_empty) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_DRAIN;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Control registers: FSM state, owning mode and sticky completion error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cur_mode <= MODE_W'(0);
            r_err_done <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_load) begin
                r_cur_mode <= in_mode;
            end else begin
                r_cur_mode <= r_cur_mode;
            end
            r_err_done <= r_err_done | w_foreign_done | w_underflow;
        end
    end

    // Output holding stage; data only changes on a load, so it is stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= {NUM_MODES{1'b0}};
            r_data_a    <= {(NUM_LANES * DATA_W){1'b0}};
            r_data_b    <= {(NUM_LANES * DATA_W){1'b0}};
        end else if (w_load) begin
            r_out_valid <= w_in_onehot;
            r_data_a    <= iA;
            r_data_b    <= iB;
        end else if (w_issue) begin
            r_out_valid <= {NUM_MODES{1'b0}};
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    // Unselected groups see zero operands.
    always_comb begin
        oA = {(NUM_MODES * NUM_LANES * DATA_W){1'b0}};
        oB = {(NUM_MODES * NUM_LANES * DATA_W){1'b0}};
        for (int m = 0; m < NUM_MODES; m++) begin
            oA[m] = r_out_valid[m] ? r_data_a : {(NUM_LANES * DATA_W){1'b0}};
            oB[m] = r_out_valid[m] ? r_data_b : {(NUM_LANES * DATA_W){1'b0}};
        end
    end

    assign in_ready  = w_in_ready & rst_n;
    assign out_valid = r_out_valid;
    assign cur_mode  = r_cur_mode;
    assign inflight  = w_inflight;
    assign err_done  = r_err_done;

endmodule

// File: tb/tb_simd_mode_router.sv
// Self-checking bench for simd_mode_router: hand tables, directed corner cases
// and random traffic against a transaction-level reference model.
module tb_simd_mode_router;
    import simd_router_pkg::*;

    localparam int NL   = 4;
    localparam int DW   = 8;
    localparam int NM   = 4;
    localparam int MAXF = 15;
    localparam int VW   = NL * DW;
    localparam int MW   = 2;
    localparam int CW   = 4;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        in_valid;
    logic                        in_ready;
    logic [MW-1:0]               in_mode;
    logic [NL-1:0][DW-1:0]       iA, iB;
    logic [NM-1:0]               out_valid, out_ready, unit_done;
    logic [NM-1:0][NL-1:0][DW-1:0] oA, oB;
    logic [MW-1:0]               cur_mode;
    logic [CW-1:0]               inflight;
    logic                        err_done;

    simd_mode_router #(
        .NUM_LANES(NL), .DATA_W(DW), .NUM_MODES(NM), .MAX_INFLIGHT(MAXF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .iA(iA), .iB(iB), .out_valid(out_valid),
        .out_ready(out_ready), .oA(oA), .oB(oB), .unit_done(unit_done),
        .cur_mode(cur_mode), .inflight(inflight), .err_done(err_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          mode;
        logic [VW-1:0] a;
        logic [VW-1:0] b;
    } vec_t;

    typedef struct {
        bit       v;
        int       mode;
        int       seed;
        logic [3:0] ordy;
        logic [3:0] done;
        bit       e_rdy;
        logic [3:0] e_ov;
        int       e_infl;
        int       e_cur;
        bit       e_err;
    } row_t;

    // Reference model: held vectors, outstanding count, owner and phase flags.
    vec_t mq[$];
    int   m_infl, m_owner;
    bit   m_free, m_drain, m_err;

    int   n_cmp, n_bad, cyc;
    bit   dut_rdy, dut_acc, dut_issue;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_infl  = 0;
        m_owner = 0;
        m_free  = 1'b1;
        m_drain = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic set_lanes(input int base);
        for (int i = 0; i < NL; i++) begin
            iA[i] = DW'(base + i);
            iB[i] = DW'(3 * base + i + 1);
        end
    endtask

    // One clock cycle: check in_ready, clock, advance the model, check outputs.
    task automatic step();
        bit held, issue, rdy, acc, done, foreign;
        logic [3:0]    exp_ov;
        logic [127:0]  exp_oa, exp_ob;
        #1;
        held  = (mq.size() != 0);
        issue = 1'b0;
        if (held) issue = out_ready[mq[0].mode];
        if (!rst_n)       rdy = 1'b0;
        else if (m_free)  rdy = 1'b1;
        else if (m_drain) rdy = 1'b0;
        else rdy = (int'(in_mode) == m_owner) && (!held || issue) && (m_infl + int'(held) < MAXF);
        dut_rdy   = in_ready;
        dut_acc   = in_valid & in_ready;
        dut_issue = |(out_valid & out_ready);
        chk("in_ready", 128'(in_ready), 128'(rdy));
        acc = in_valid && rdy;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            done    = unit_done[m_owner];
            foreign = (unit_done & ~(4'b0001 << m_owner)) != 4'b0000;
            if (foreign || (done && m_infl == 0)) m_err = 1'b1;
            if (m_free) begin
                if (in_valid) begin
                    m_free  = 1'b0;
                    m_owner = int'(in_mode);
                end
            end else if (m_drain) begin
                if (!held && m_infl == 0) begin
                    m_drain = 1'b0;
                    m_free  = 1'b1;
                end
            end else if (in_valid && int'(in_mode) != m_owner) begin
                m_drain = 1'b1;
            end
            m_infl = m_infl + (issue ? 1 : 0) - ((done && m_infl > 0) ? 1 : 0);
            if (issue) void'(mq.pop_front());
            if (acc) mq.push_back('{int'(in_mode), iA, iB});
        end
        #1;
        exp_ov = 4'b0000;
        exp_oa = 128'd0;
        exp_ob = 128'd0;
        if (mq.size() != 0) begin
            exp_ov = 4'b0001 << mq[0].mode;
            exp_oa[mq[0].mode * VW +: VW] = mq[0].a;
            exp_ob[mq[0].mode * VW +: VW] = mq[0].b;
        end
        chk("out_valid", 128'(out_valid), 128'(exp_ov));
        chk("oA", 128'(oA), exp_oa);
        chk("oB", 128'(oB), exp_ob);
        chk("cur_mode", 128'(cur_mode), 128'(m_owner));
        chk("inflight", 128'(inflight), 128'(m_infl));
        chk("err_done", 128'(err_done), 128'(m_err));
        cyc++;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        unit_done = 4'b0000;
        step();
        rst_n = 1'b1;
    endtask

    task automatic drain_all();
        in_valid  = 1'b0;
        out_ready = 4'b1111;
        for (int c = 0; c < 40; c++) begin
            if (mq.size() == 0 && m_infl == 0) break;
            unit_done = (m_infl > 0) ? (4'b0001 << m_owner) : 4'b0000;
            step();
        end
        unit_done = 4'b0000;
        chk("drain_empty", 128'(inflight), 128'd0);
    endtask

    row_t tbl[11];
    int   iss, nacc, last_done, lat;
    logic [VW-1:0] held_a;

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0;
        model_reset();

        // Reset with a valid request present.
        rst_n = 1'b0; in_valid = 1'b1; in_mode = 2'd2; set_lanes(5);
        out_ready = 4'b1111; unit_done = 4'b0000;
        step(); step();
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_oA", 128'(oA), 128'd0);
        chk("rst_oB", 128'(oB), 128'd0);
        chk("rst_cur_mode", 128'(cur_mode), 128'd0);
        chk("rst_inflight", 128'(inflight), 128'd0);
        chk("rst_in_ready", 128'(dut_rdy), 128'd0);
        rst_n = 1'b1; in_valid = 1'b0;

        // Hand-computed cycle table: load, stall, issue, drain, switch, errors.
        tbl[0]  = '{1'b1, 0, 16, 4'b0000, 4'b0000, 1'b1, 4'b0001, 0, 0, 1'b0};
        tbl[1]  = '{1'b1, 0, 32, 4'b0000, 4'b0000, 1'b0, 4'b0001, 0, 0, 1'b0};
        tbl[2]  = '{1'b1, 0, 48, 4'b0001, 4'b0000, 1'b1, 4'b0001, 1, 0, 1'b0};
        tbl[3]  = '{1'b0, 0, 64, 4'b0001, 4'b0001, 1'b1, 4'b0000, 1, 0, 1'b0};
        tbl[4]  = '{1'b1, 1, 80, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1, 0, 1'b0};
        tbl[5]  = '{1'b1, 1, 80, 4'b0000, 4'b0001, 1'b0, 4'b0000, 0, 0, 1'b0};
        tbl[6]  = '{1'b1, 1, 80, 4'b0000, 4'b0000, 1'b0, 4'b0000, 0, 0, 1'b0};
        tbl[7]  = '{1'b1, 1, 96, 4'b0000, 4'b0000, 1'b1, 4'b0010, 0, 1, 1'b0};
        tbl[8]  = '{1'b0, 1, 0,  4'b0010, 4'b0100, 1'b1, 4'b0000, 1, 1, 1'b1};
        tbl[9]  = '{1'b0, 1, 0,  4'b0000, 4'b0010, 1'b1, 4'b0000, 0, 1, 1'b1};
        tbl[10] = '{1'b0, 1, 0,  4'b0000, 4'b0010, 1'b1, 4'b0000, 0, 1, 1'b1};
        for (int r = 0; r < 11; r++) begin
            in_valid  = tbl[r].v;
            in_mode   = MW'(tbl[r].mode);
            set_lanes(tbl[r].seed);
            out_ready = tbl[r].ordy;
            unit_done = tbl[r].done;
            step();
            chk("tbl_in_ready", 128'(dut_rdy), 128'(tbl[r].e_rdy));
            chk("tbl_out_valid", 128'(out_valid), 128'(tbl[r].e_ov));
            chk("tbl_inflight", 128'(inflight), 128'(tbl[r].e_infl));
            chk("tbl_cur_mode", 128'(cur_mode), 128'(tbl[r].e_cur));
            chk("tbl_err_done", 128'(err_done), 128'(tbl[r].e_err));
        end
        do_reset();

        // Streaming: 8 MAC vectors, done 3 cycles after each issue.
        begin
            int due[$];
            int k;
            k = 0; iss = 0;
            for (int c = 0; c < 60; c++) begin
                in_valid  = (k < 8);
                in_mode   = MW'(MODE_MAC);
                set_lanes(k);
                out_ready = 4'b0001;
                unit_done = 4'b0000;
                if (due.size() != 0 && due[0] == cyc) begin
                    unit_done = 4'b0001;
                    void'(due.pop_front());
                end
                step();
                if (dut_acc) k++;
                if (dut_issue) begin
                    iss++;
                    due.push_back(cyc - 1 + 3);
                end
            end
            unit_done = 4'b0000;
            chk("stream_issues", 128'(iss), 128'd8);
            chk("stream_final_inflight", 128'(inflight), 128'd0);
        end

        // Backpressure: held vector must stay put for 5 stalled cycles.
        in_valid = 1'b1; in_mode = MW'(MODE_MAC); set_lanes(64); out_ready = 4'b0000;
        held_a = iA;
        step();
        for (int c = 0; c < 5; c++) begin
            set_lanes(80 + c);
            step();
            chk("bp_in_ready", 128'(dut_rdy), 128'd0);
            chk("bp_hold", 128'(oA[0]), 128'(held_a));
        end
        in_valid = 1'b0; out_ready = 4'b0001;
        step();
        chk("bp_issue", 128'(dut_issue), 128'd1);
        drain_all();

        // Saturation: 15 issues with no completions, then one done buys one more.
        iss = 0; in_valid = 1'b1; in_mode = MW'(MODE_MAC); out_ready = 4'b0001; unit_done = 4'b0000;
        for (int c = 0; c < 25; c++) begin
            set_lanes(100 + c);
            step();
            if (dut_issue) iss++;
        end
        chk("sat_issues", 128'(iss), 128'd15);
        chk("sat_in_ready", 128'(dut_rdy), 128'd0);
        chk("sat_inflight", 128'(inflight), 128'd15);
        unit_done = 4'b0001;
        step();
        unit_done = 4'b0000; iss = 0; nacc = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (dut_acc) nacc++;
            if (dut_issue) iss++;
        end
        chk("sat_resume_accepts", 128'(nacc), 128'd1);
        chk("sat_resume_issues", 128'(iss), 128'd1);
        drain_all();

        // Mode switch: 3 MAC issues, DIV waits for 3 dones, then 2 cycles to out_valid.
        nacc = 0; in_valid = 1'b1; in_mode = MW'(MODE_MAC); out_ready = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            if (nacc == 3) break;
            set_lanes(128 + c);
            step();
            if (dut_acc) nacc++;
        end
        in_mode = MW'(MODE_DIV); out_ready = 4'b1111; set_lanes(160); nacc = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (dut_acc) nacc++;
        end
        last_done = -1;
        for (int d = 0; d < 3; d++) begin
            if (d > 0) begin
                step();
                if (dut_acc) nacc++;
            end
            unit_done = 4'b0001;
            step();
            if (dut_acc) nacc++;
            last_done = cyc - 1;
            unit_done = 4'b0000;
        end
        chk("switch_no_early_accept", 128'(nacc), 128'd0);
        lat = -1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (out_valid == 4'b0010) begin
                lat = cyc - 1 - last_done;
                break;
            end
        end
        chk("switch_latency", 128'(lat), 128'd2);
        drain_all();

        // Errors: foreign done keeps inflight, reset clears, late done and underflow flag.
        chk("err_clear_before", 128'(err_done), 128'd0);
        in_valid = 1'b1; in_mode = MW'(MODE_DIV); out_ready = 4'b0010; set_lanes(200);
        step();
        in_valid = 1'b0;
        step();
        unit_done = 4'b0100;
        step();
        unit_done = 4'b0000;
        chk("err_foreign", 128'(err_done), 128'd1);
        chk("err_foreign_inflight", 128'(inflight), 128'd1);
        rst_n = 1'b0;
        step();
        chk("midrst_inflight", 128'(inflight), 128'd0);
        chk("midrst_err", 128'(err_done), 128'd0);
        rst_n = 1'b1; unit_done = 4'b0010;
        step();
        unit_done = 4'b0000;
        chk("late_done_err", 128'(err_done), 128'd1);
        do_reset();
        unit_done = 4'b0001;
        step();
        unit_done = 4'b0000;
        chk("err_underflow", 128'(err_done), 128'd1);
        chk("err_underflow_inflight", 128'(inflight), 128'd0);
        step();
        chk("err_sticky", 128'(err_done), 128'd1);

        // Random traffic against the model, with one reset in the middle.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_mode   = ($urandom_range(0, 9) < 8) ? MW'(m_owner) : MW'($urandom_range(0, NM - 1));
            iA        = VW'($urandom);
            iB        = VW'($urandom);
            out_ready = NM'($urandom);
            unit_done = 4'b0000;
            if (m_infl > 0 && $urandom_range(0, 9) < 3) unit_done = 4'b0001 << m_owner;
            if ($urandom_range(0, 99) == 0) unit_done = unit_done | (4'b0001 << $urandom_range(0, NM - 1));
            rst_n = (c != 700);
            step();
        end
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/simd_mode_router.md
# simd_mode_router

Parametrised, registered mode router for the SIMD array front end. It accepts one lane-vector operand pair per handshake, each tagged with an operation mode, and steers it to exactly one of `NUM_MODES` functional-unit groups (MAC, DIV, EXP, LOG, …). Unselected groups see zeroed operands. On a mode change, the router drains in-flight work from the old unit before issuing to the new one. It sits between the operand fetch stage and the per-mode unit arrays.

## Interface
Parameters:
- `NUM_LANES`, 64, lanes per vector.
- `DATA_W`, `` `MAC_BW ``, bits per lane operand.
- `NUM_MODES`, 4, number of functional-unit groups; must be ≥2.
- `MAX_INFLIGHT`, 15, maximum outstanding issued-but-not-done vectors; must be ≥1.

Ports (`MODE_W = $clog2(NUM_MODES)`, `CNT_W = $clog2(MAX_INFLIGHT+1)`):
- `clk`, input, 1, clock.
- `rst_n`, input, 1, asynchronous active-low reset.
- `in_valid`, input, 1, operand vector valid.
- `in_ready`, output, 1, router accepts this cycle.
- `in_mode`, input, `MODE_W`, target unit group.
- `iA`, input, `NUM_LANES`×`DATA_W`, operand A lanes.
- `iB`, input, `NUM_LANES`×`DATA_W`, operand B lanes.
- `out_valid`, output, `NUM_MODES`, per-group valid; at most one bit set.
- `out_ready`, input, `NUM_MODES`, per-group ready.
- `oA`, output, `NUM_MODES`×`NUM_LANES`×`DATA_W`, per-group operand A.
- `oB`, output, `NUM_MODES`×`NUM_LANES`×`DATA_W`, per-group operand B.
- `unit_done`, input, `NUM_MODES`, one-cycle pulse per completed vector.
- `cur_mode`, output, `MODE_W`, mode currently owning the array.
- `inflight`, output, `CNT_W`, outstanding vector count.
- `err_done`, output, 1, sticky; set by `unit_done` from a non-current group or while `inflight==0`.

## Operation
- Single output register stage: a held vector, its mode, and a valid flag.
- `oA[m]`/`oB[m]` carry the held data only when `m == held mode` and the output is valid; all other bits are 0.
- Issue handshake: `out_valid[held_mode] & out_ready[held_mode]`. Each issue increments `inflight`.
- Decrement: `unit_done[cur_mode]` decrements `inflight`. A simultaneous issue and done leaves `inflight` unchanged.
- FSM states:
  - IDLE (`inflight==0`, output empty): `in_valid` loads the register, sets `cur_mode=in_mode`, and moves to RUN.
  - RUN: accept only if `in_mode==cur_mode`, the output is empty or being issued this cycle, and `inflight + pending < MAX_INFLIGHT`. A valid input with `in_mode!=cur_mode` deasserts `in_ready` and moves to DRAIN.
  - DRAIN: `in_ready=0`. When the output is empty and `inflight==0`, move to IDLE. The new mode is accepted the following cycle.
- Done pulses on non-current groups are ignored and set `err_done`. Done with `inflight==0` is ignored (no underflow) and sets `err_done`.
- `in_ready` is combinational from state, counter, and `out_ready`. No combinational path exists from `in_valid` to `in_ready`.

## Timing
- Reset values: `out_valid=0`, `oA=oB=0`, `in_ready=0` during reset, state=IDLE, `cur_mode=0`, `inflight=0`, `err_done=0`.
- Latency: input accepted at edge N drives `out_valid` from N (registered, visible in cycle N+1).
- Throughput: 1 vector/cycle in RUN when `out_ready` is held high and the counter is not saturated.
- `inflight` saturation: `in_ready=0` once issued plus held vectors reach `MAX_INFLIGHT`. Acceptance resumes the cycle after a done pulse.
- Mode-switch penalty: drain time plus 1 cycle (DRAIN→IDLE) before the new-mode vector is accepted.
- Held data is stable while `out_valid[m]=1` and `out_ready[m]=0`.
- Reset mid-operation: all state clears immediately. Pending done pulses arriving after reset set `err_done`.

## Structure
- Package `simd_router_pkg`: state enum (`ST_IDLE`, `ST_RUN`, `ST_DRAIN`) and mode constants (`MODE_MAC=0`, `MODE_DIV=1`, `MODE_EXP=2`, `MODE_LOG=3`).
- Sub-module `inflight_counter`: up/down saturating counter with `inc`, `dec`, `full`, `empty`, and underflow-error outputs. The remaining logic is a single module.

## Test plan
- Reset: drive `rst_n=0` with `in_valid=1` → all `out_valid` 0, `oA`/`oB` all 0, `cur_mode=0`, `inflight=0`.
- Streaming: 8 MAC vectors with lane values `i+k`, `out_ready` held at 1, `unit_done[0]` 3 cycles after each issue → 8 issues, `out_valid=4'b0001` only, `oA[1..3]==0`, final `inflight=0`.
- Backpressure: `out_ready[0]=0` for 5 cycles → held data unchanged, `in_ready=0`, no data loss when released.
- Mode switch: 3 MAC issues, then a DIV request → `in_ready=0` until 3 `unit_done[0]` pulses. First DIV `out_valid=4'b0010` appears 2 cycles after the last done.
- Saturation: `MAX_INFLIGHT=15`, no done pulses → exactly 15 issues, then stall. One done pulse → one more accept.
- Error: `unit_done[2]` while `cur_mode=0`, and `unit_done[0]` with `inflight=0` → `err_done=1` sticky, `inflight` unchanged.
